// File: rtl/video_pkg.sv
// Shared FSM state type and default 640x480@60 timing for the video window generator.
package video_pkg;

  typedef enum logic {
    FWD = 1'b0,
    REV = 1'b1
  } dir_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_IMG_W    = 225;
  localparam int DEF_IMG_H    = 225;
  localparam int DEF_STEP     = 1;
  localparam int DEF_CW       = 12;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the window motion: walks 0..MAX in STEP increments and reverses at
// either end. The position only changes on cycles where step_en_i is high.
module bounce_axis
  import video_pkg::*;
#(
  parameter int MAX  = DEF_H_ACTIVE - DEF_IMG_W,
  parameter int STEP = DEF_STEP,
  parameter int CW   = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          step_en_i,
  output logic [CW-1:0] pos_o
);

  localparam logic [CW:0] MAX_W  = (CW+1)'(MAX);
  localparam logic [CW:0] STEP_W = (CW+1)'(STEP);

  dir_e          dir_q;
  logic [CW-1:0] pos_q;
  logic [CW:0]   fwd_sum;

  // One extra bit so the forward sum cannot wrap before it is compared with MAX.
  assign fwd_sum = {1'b0, pos_q} + STEP_W;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= FWD;
      pos_q <= '0;
    end else if (step_en_i) begin
      if (MAX == 0) begin
        dir_q <= FWD;
        pos_q <= '0;
      end else begin
        case (dir_q)
          FWD: begin
            if (fwd_sum >= MAX_W) begin
              pos_q <= MAX_W[CW-1:0];
              dir_q <= REV;
            end else begin
              pos_q <= fwd_sum[CW-1:0];
            end
          end
          REV: begin
            if ({1'b0, pos_q} <= STEP_W) begin
              pos_q <= '0;
              dir_q <= FWD;
            end else begin
              pos_q <= pos_q - STEP_W[CW-1:0];
            end
          end
          default: begin
            pos_q <= '0;
            dir_q <= FWD;
          end
        endcase
      end
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/video_window_gen.sv
// Raster timing generator with a bouncing rectangular window overlay.
// Define VWG_REG_OUT_EN to add one register stage on every output (1-cycle latency).
module video_window_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int STEP     = DEF_STEP,
  parameter int CW       = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          i_move_en,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_win,
  output logic [CW-1:0] o_win_x,
  output logic [CW-1:0] o_win_y,
  output logic          o_frame_start,
  output logic          o_line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0]   IMG_WW = (CW+1)'(IMG_W);
  localparam logic [CW:0]   IMG_HW = (CW+1)'(IMG_H);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          armed_q;
  logic          h_last, v_last, pos_step;
  logic [CW-1:0] pos_x, pos_y;
  logic [CW:0]   x_end, y_end;
  logic          in_x, in_y;

  logic          hs_d, vs_d, de_d, win_d, fs_d, ls_d;
  logic [CW-1:0] win_x_d, win_y_d;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    h_d = h_q + ONE;
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + ONE;
    end
  end

  // Counters leave reset parked on the last pixel; armed_q skips that first
  // frame-end so the first frame after reset is drawn at the origin.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      armed_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      armed_q <= 1'b1;
    end
  end

  assign pos_step = armed_q && i_move_en && h_last && v_last;

  bounce_axis #(
    .MAX (H_ACTIVE - IMG_W),
    .STEP(STEP),
    .CW  (CW)
  ) u_bounce_x (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .step_en_i(pos_step),
    .pos_o    (pos_x)
  );

  bounce_axis #(
    .MAX (V_ACTIVE - IMG_H),
    .STEP(STEP),
    .CW  (CW)
  ) u_bounce_y (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .step_en_i(pos_step),
    .pos_o    (pos_y)
  );

  assign x_end = {1'b0, pos_x} + IMG_WW;
  assign y_end = {1'b0, pos_y} + IMG_HW;
  assign in_x  = (h_q >= pos_x) && ({1'b0, h_q} < x_end);
  assign in_y  = (v_q >= pos_y) && ({1'b0, v_q} < y_end);

  assign hs_d    = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_d    = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign de_d    = (h_q < H_ACT) && (v_q < V_ACT);
  assign win_d   = in_x && in_y;
  assign win_x_d = win_d ? (h_q - pos_x) : '0;
  assign win_y_d = win_d ? (v_q - pos_y) : '0;
  assign ls_d    = (h_q == '0);
  assign fs_d    = (h_q == '0) && (v_q == '0);

`ifdef VWG_REG_OUT_EN
  logic          hs_q, vs_q, de_q, win_q, fs_q, ls_q;
  logic [CW-1:0] x_q, y_q, win_x_q, win_y_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      win_q   <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      win_q   <= win_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      x_q     <= h_q;
      y_q     <= v_q;
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_de          = de_q;
  assign o_win         = win_q;
  assign o_frame_start = fs_q;
  assign o_line_start  = ls_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_win_x       = win_x_q;
  assign o_win_y       = win_y_q;
`else
  assign o_hs          = hs_d;
  assign o_vs          = vs_d;
  assign o_de          = de_d;
  assign o_win         = win_d;
  assign o_frame_start = fs_d;
  assign o_line_start  = ls_d;
  assign o_x           = h_q;
  assign o_y           = v_q;
  assign o_win_x       = win_x_d;
  assign o_win_y       = win_y_d;
`endif

endmodule
